// File: rtl/mux_channel_scanner.sv
// Steps a 4:1 mux through channels 0..3, settles, samples and emits a 4-bit frame
// over valid/ready. Optional change flag against the last accepted frame: SCAN_CHANGE_DET_EN.
module mux_channel_scanner #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic       mux_out_in,
    output logic [1:0] select,
    output logic       busy,
    output logic [3:0] frame_data,
    output logic       frame_valid,
    input  logic       frame_ready
`ifdef SCAN_CHANGE_DET_EN
   ,output logic       frame_changed
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [2:0]       shadow_q, shadow_d;
    logic [3:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
`ifdef SCAN_CHANGE_DET_EN
    logic [3:0]       last_q, last_d;
    logic             changed_q, changed_d;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = valid_q;
`ifdef SCAN_CHANGE_DET_EN
        last_d    = last_q;
        changed_d = changed_q;
`endif
        case (state_q)
            ST_IDLE: begin
                sel_d = 2'd0;
                if (start) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (sel_q != 2'd3) begin
                    for (int unsigned i = 0; i < 3; i++) begin
                        if (sel_q == 2'(i)) begin
                            shadow_d[i] = mux_out_in;
                        end
                    end
                    sel_d   = sel_q + 2'd1;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end else begin
                    data_d  = {mux_out_in, shadow_q};
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
`ifdef SCAN_CHANGE_DET_EN
                    changed_d = ({mux_out_in, shadow_q} != last_q);
`endif
                end
            end
            ST_HOLD: begin
                // select wraps to channel 0 only through the handshake
                if (valid_q && frame_ready) begin
                    valid_d = 1'b0;
                    sel_d   = 2'd0;
                    cnt_d   = '0;
                    state_d = cont ? ST_SETTLE : ST_IDLE;
`ifdef SCAN_CHANGE_DET_EN
                    last_d    = data_q;
                    changed_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = 2'd0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sel_q    <= 2'd0;
            shadow_q <= 3'd0;
            data_q   <= 4'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SCAN_CHANGE_DET_EN
            last_q    <= 4'd0;
            changed_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
`ifdef SCAN_CHANGE_DET_EN
            last_q    <= last_d;
            changed_q <= changed_d;
`endif
        end
    end

    assign select      = sel_q;
    assign busy        = busy_q;
    assign frame_data  = data_q;
    assign frame_valid = valid_q;
`ifdef SCAN_CHANGE_DET_EN
    assign frame_changed = changed_q;
`endif

endmodule
